// File: rtl/ram_arbiter_if.sv
// Shared-RAM arbiter bus: two requesting masters on one side and the RAM
// read/write ports on the other.
interface ram_arbiter_if #(
  parameter int AWIDTH = 8,
  parameter int DWIDTH = 16
);
  logic              m0_req;
  logic              m0_we;
  logic [AWIDTH-1:0] m0_addr;
  logic [DWIDTH-1:0] m0_wdata;
  logic              m0_gnt;
  logic              m0_rvalid;
  logic [DWIDTH-1:0] m0_rdata;

  logic              m1_req;
  logic              m1_we;
  logic [AWIDTH-1:0] m1_addr;
  logic [DWIDTH-1:0] m1_wdata;
  logic              m1_gnt;
  logic              m1_rvalid;
  logic [DWIDTH-1:0] m1_rdata;

  logic              ram_rd;
  logic              ram_wr;
  logic [AWIDTH-1:0] ram_raddr;
  logic [AWIDTH-1:0] ram_waddr;
  logic [DWIDTH-1:0] ram_wdata;
  logic [DWIDTH-1:0] ram_rdata;

  modport slave (
    input  m0_req, m0_we, m0_addr, m0_wdata,
    input  m1_req, m1_we, m1_addr, m1_wdata,
    input  ram_rdata,
    output m0_gnt, m0_rvalid, m0_rdata,
    output m1_gnt, m1_rvalid, m1_rdata,
    output ram_rd, ram_wr, ram_raddr, ram_waddr, ram_wdata
  );

  modport master (
    output m0_req, m0_we, m0_addr, m0_wdata,
    output m1_req, m1_we, m1_addr, m1_wdata,
    output ram_rdata,
    input  m0_gnt, m0_rvalid, m0_rdata,
    input  m1_gnt, m1_rvalid, m1_rdata,
    input  ram_rd, ram_wr, ram_raddr, ram_waddr, ram_wdata
  );
endinterface

// File: rtl/ram_arbiter.sv
// Two-master arbiter for the shared data RAM: one access per cycle, read data
// steered back to its owner one cycle after the grant.
module ram_arbiter #(
  parameter int AWIDTH       = 8,
  parameter int DWIDTH       = 16,
  parameter int FIXED_PRIO   = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic         clk,
  input  logic         rst,
  ram_arbiter_if.slave bus
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic              last_gnt;
  logic [3:0]        starve_cnt;
  logic              rd_pend;
  logic              rd_owner;

  logic              req0;
  logic              req1;
  logic              win1;
  logic              gnt0;
  logic              gnt1;
  logic              acc;
  logic              acc_we;
  logic [AWIDTH-1:0] acc_addr;
  logic [DWIDTH-1:0] acc_wdata;
  logic              rd_go;
  logic              wr_go;

  function automatic logic [3:0] starve_sat_inc(input logic [3:0] cnt);
    return (cnt >= LIMIT) ? LIMIT : cnt + 4'd1;
  endfunction

  // Stage p0: combinational grant and RAM port steering
  always_comb begin
    req0 = bus.m0_req & ~rst;
    req1 = bus.m1_req & ~rst;
    // On conflict: starvation guard in fixed mode, "not last winner" in round-robin
    win1 = (FIXED_PRIO != 0) ? (starve_cnt == LIMIT) : ~last_gnt;
    gnt0 = req0 & ~(req1 & win1);
    gnt1 = req1 & ~(req0 & ~win1);
    acc  = gnt0 | gnt1;

    acc_we    = gnt1 ? bus.m1_we    : bus.m0_we;
    acc_addr  = gnt1 ? bus.m1_addr  : bus.m0_addr;
    acc_wdata = gnt1 ? bus.m1_wdata : bus.m0_wdata;

    rd_go = acc & ~acc_we;
    wr_go = acc & acc_we;
  end

  assign bus.m0_gnt    = gnt0;
  assign bus.m1_gnt    = gnt1;
  assign bus.ram_rd    = rd_go;
  assign bus.ram_wr    = wr_go;
  assign bus.ram_raddr = rd_go ? acc_addr  : '0;
  assign bus.ram_waddr = wr_go ? acc_addr  : '0;
  assign bus.ram_wdata = wr_go ? acc_wdata : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      last_gnt   <= 1'b1;
      starve_cnt <= 4'd0;
      rd_pend    <= 1'b0;
    end else begin
      if (acc) begin
        last_gnt <= gnt1;
      end
      if (!bus.m1_req || gnt1) begin
        starve_cnt <= 4'd0;
      end else begin
        starve_cnt <= starve_sat_inc(starve_cnt);
      end
      rd_pend <= rd_go;
    end
  end

  // Owner tag only qualifies data, so it needs no reset
  always_ff @(posedge clk) begin
    rd_owner <= gnt1;
  end

  // Stage p1: read response routing
  assign bus.m0_rvalid = rd_pend & ~rd_owner;
  assign bus.m1_rvalid = rd_pend & rd_owner;
  assign bus.m0_rdata  = (rd_pend & ~rd_owner) ? bus.ram_rdata : '0;
  assign bus.m1_rdata  = (rd_pend & rd_owner)  ? bus.ram_rdata : '0;

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: a fixed-priority and a round-robin instance driven
// with identical master traffic, each compared with a behavioural model.
module tb_ram_arbiter;
  localparam int AW  = 8;
  localparam int DW  = 16;
  localparam int LIM = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          m0_req, m1_req, m0_we, m1_we;
  logic [AW-1:0] m0_addr, m1_addr;
  logic [DW-1:0] m0_wdata, m1_wdata;

  ram_arbiter_if #(.AWIDTH(AW), .DWIDTH(DW)) bus_fp ();
  ram_arbiter_if #(.AWIDTH(AW), .DWIDTH(DW)) bus_rr ();

  assign bus_fp.m0_req = m0_req;     assign bus_rr.m0_req = m0_req;
  assign bus_fp.m0_we = m0_we;       assign bus_rr.m0_we = m0_we;
  assign bus_fp.m0_addr = m0_addr;   assign bus_rr.m0_addr = m0_addr;
  assign bus_fp.m0_wdata = m0_wdata; assign bus_rr.m0_wdata = m0_wdata;
  assign bus_fp.m1_req = m1_req;     assign bus_rr.m1_req = m1_req;
  assign bus_fp.m1_we = m1_we;       assign bus_rr.m1_we = m1_we;
  assign bus_fp.m1_addr = m1_addr;   assign bus_rr.m1_addr = m1_addr;
  assign bus_fp.m1_wdata = m1_wdata; assign bus_rr.m1_wdata = m1_wdata;

  ram_arbiter #(.AWIDTH(AW), .DWIDTH(DW), .FIXED_PRIO(1), .STARVE_LIMIT(LIM)) dut_fp (
    .clk(clk), .rst(rst), .bus(bus_fp));
  ram_arbiter #(.AWIDTH(AW), .DWIDTH(DW), .FIXED_PRIO(0), .STARVE_LIMIT(LIM)) dut_rr (
    .clk(clk), .rst(rst), .bus(bus_rr));

  // Power-up RAM contents, with the 0xBEEF word the solo-read step expects
  function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
    return (a == 8'h10) ? 16'hBEEF : {a, ~a};
  endfunction

  // RAM instances: write on the edge, registered read
  logic [DW-1:0] ram_fp [256];
  logic [DW-1:0] ram_rr [256];
  bit            wr_fp  [256];
  bit            wr_rr  [256];

  always @(posedge clk) begin
    if (bus_fp.ram_wr) begin
      ram_fp[bus_fp.ram_waddr] <= bus_fp.ram_wdata;
      wr_fp[bus_fp.ram_waddr]  <= 1'b1;
    end
    if (bus_fp.ram_rd)
      bus_fp.ram_rdata <= wr_fp[bus_fp.ram_raddr] ? ram_fp[bus_fp.ram_raddr] : pat(bus_fp.ram_raddr);
    if (bus_rr.ram_wr) begin
      ram_rr[bus_rr.ram_waddr] <= bus_rr.ram_wdata;
      wr_rr[bus_rr.ram_waddr]  <= 1'b1;
    end
    if (bus_rr.ram_rd)
      bus_rr.ram_rdata <= wr_rr[bus_rr.ram_raddr] ? ram_rr[bus_rr.ram_raddr] : pat(bus_rr.ram_raddr);
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model, index 0 = fixed priority, 1 = round-robin
  logic [DW-1:0] mdl_mem [2][256];
  int            last_w [2];
  int            starve [2];
  bit            pend   [2];
  int            owner  [2];
  logic [DW-1:0] pdata  [2];

  task automatic model_step(input int k, input string nm,
                            input logic g0, input logic g1, input logic rd, input logic wr,
                            input logic [AW-1:0] ra, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                            input logic rv0, input logic rv1,
                            input logic [DW-1:0] rd0, input logic [DW-1:0] rd1);
    bit            r0, r1, we;
    int            win;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    r0 = m0_req && !rst;
    r1 = m1_req && !rst;
    if (r0 && r1) begin
      if (k == 0) win = (starve[k] == LIM) ? 1 : 0;
      else        win = (last_w[k] == 0) ? 1 : 0;
    end else if (r0) win = 0;
    else if (r1)     win = 1;
    else             win = -1;
    we = (win == 1) ? m1_we : m0_we;
    a  = (win == 1) ? m1_addr : m0_addr;
    d  = (win == 1) ? m1_wdata : m0_wdata;

    chk({nm, ".gnt0"}, g0, win == 0);
    chk({nm, ".gnt1"}, g1, win == 1);
    chk({nm, ".ram_rd"}, rd, win >= 0 && !we);
    chk({nm, ".ram_wr"}, wr, win >= 0 && we);
    chk({nm, ".ram_raddr"}, ra, (win >= 0 && !we) ? a : 8'h00);
    chk({nm, ".ram_waddr"}, wa, (win >= 0 && we) ? a : 8'h00);
    chk({nm, ".ram_wdata"}, wd, (win >= 0 && we) ? d : 16'h0000);
    chk({nm, ".rvalid0"}, rv0, pend[k] && owner[k] == 0);
    chk({nm, ".rvalid1"}, rv1, pend[k] && owner[k] == 1);
    chk({nm, ".rdata0"}, rd0, (pend[k] && owner[k] == 0) ? pdata[k] : 16'h0000);
    chk({nm, ".rdata1"}, rd1, (pend[k] && owner[k] == 1) ? pdata[k] : 16'h0000);

    if (rst) begin
      last_w[k] = 1;
      starve[k] = 0;
      pend[k]   = 1'b0;
    end else begin
      if (win >= 0) last_w[k] = win;
      if (!m1_req || win == 1) starve[k] = 0;
      else if (starve[k] < LIM) starve[k] = starve[k] + 1;
      pend[k]  = (win >= 0) && !we;
      owner[k] = win;
      if (win >= 0 && !we) pdata[k] = mdl_mem[k][a];
      if (win >= 0 && we)  mdl_mem[k][a] = d;
    end
  endtask

  task automatic sample();
    @(negedge clk);
    model_step(0, "fp", bus_fp.m0_gnt, bus_fp.m1_gnt, bus_fp.ram_rd, bus_fp.ram_wr,
               bus_fp.ram_raddr, bus_fp.ram_waddr, bus_fp.ram_wdata,
               bus_fp.m0_rvalid, bus_fp.m1_rvalid, bus_fp.m0_rdata, bus_fp.m1_rdata);
    model_step(1, "rr", bus_rr.m0_gnt, bus_rr.m1_gnt, bus_rr.ram_rd, bus_rr.ram_wr,
               bus_rr.ram_raddr, bus_rr.ram_waddr, bus_rr.ram_wdata,
               bus_rr.m0_rvalid, bus_rr.m1_rvalid, bus_rr.m0_rdata, bus_rr.m1_rdata);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input bit r0, input bit w0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                     input bit r1, input bit w1, input logic [AW-1:0] a1, input logic [DW-1:0] d1);
    m0_req = r0; m0_we = w0; m0_addr = a0; m0_wdata = d0;
    m1_req = r1; m1_we = w1; m1_addr = a1; m1_wdata = d1;
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 256; i++) mdl_mem[k][i] = pat(AW'(i));
      last_w[k] = 1; starve[k] = 0; pend[k] = 1'b0; owner[k] = 0; pdata[k] = '0;
    end

    // Reset held with both masters requesting
    rst = 1'b1;
    drv(1, 0, 8'h01, 16'h0, 1, 0, 8'h02, 16'h0);
    tick();
    for (int i = 0; i < 3; i++) begin
      sample();
      chk("rst.fp.gnt0", bus_fp.m0_gnt, 0);
      chk("rst.rr.gnt1", bus_rr.m1_gnt, 0);
      chk("rst.fp.ram_rd", bus_fp.ram_rd, 0);
      tick();
    end

    // Continuous conflict: starvation guard vs. alternation
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      drv(1, 0, AW'(8'h20 + i), 16'h0, 1, 0, AW'(8'h40 + i), 16'h0);
      sample();
      chk("starve.fp.gnt1", bus_fp.m1_gnt, (i % 5) == 4);
      chk("rr.alt.gnt1", bus_rr.m1_gnt, (i % 2) == 1);
      tick();
    end
    drv(0, 0, 8'h00, 16'h0, 0, 0, 8'h00, 16'h0);
    sample(); tick();

    // Solo read of the 0xBEEF word
    drv(1, 0, 8'h10, 16'h0, 0, 0, 8'h00, 16'h0);
    sample();
    chk("solo.fp.gnt0", bus_fp.m0_gnt, 1);
    chk("solo.rr.gnt0", bus_rr.m0_gnt, 1);
    tick();
    drv(0, 0, 8'h00, 16'h0, 0, 0, 8'h00, 16'h0);
    sample();
    chk("solo.rvalid0", bus_fp.m0_rvalid, 1);
    chk("solo.rdata0", bus_fp.m0_rdata, 16'hBEEF);
    chk("solo.rvalid1", bus_fp.m1_rvalid, 0);
    tick();

    // m1 writes, m0 reads the same word two cycles later
    drv(0, 0, 8'h00, 16'h0, 1, 1, 8'h05, 16'h1234);
    sample();
    chk("wr.ram_wr", bus_fp.ram_wr, 1);
    chk("wr.ram_waddr", bus_fp.ram_waddr, 8'h05);
    tick();
    drv(0, 0, 8'h00, 16'h0, 0, 0, 8'h00, 16'h0);
    sample();
    chk("wr.idle_waddr", bus_fp.ram_waddr, 8'h00);
    tick();
    drv(1, 0, 8'h05, 16'h0, 0, 0, 8'h00, 16'h0);
    sample(); tick();
    drv(0, 0, 8'h00, 16'h0, 0, 0, 8'h00, 16'h0);
    sample();
    chk("raw.fp.rdata0", bus_fp.m0_rdata, 16'h1234);
    chk("raw.rr.rdata0", bus_rr.m0_rdata, 16'h1234);
    tick();

    // Starve counter at its limit while m1 drops its request
    for (int i = 0; i < 4; i++) begin
      drv(1, 0, AW'(8'h60 + i), 16'h0, 1, 0, 8'h70, 16'h0);
      sample(); tick();
    end
    drv(1, 0, 8'h64, 16'h0, 0, 0, 8'h70, 16'h0);
    sample();
    chk("drop.fp.gnt0", bus_fp.m0_gnt, 1);
    tick();
    drv(1, 0, 8'h65, 16'h0, 1, 0, 8'h70, 16'h0);
    sample();
    chk("drop.after.gnt0", bus_fp.m0_gnt, 1);
    tick();

    // Reset arriving the cycle after a read grant
    drv(1, 0, 8'h33, 16'h0, 0, 0, 8'h00, 16'h0);
    sample();
    chk("rstmid.gnt0", bus_fp.m0_gnt, 1);
    tick();
    rst = 1'b1;
    drv(1, 0, 8'h34, 16'h0, 0, 0, 8'h00, 16'h0);
    sample();
    chk("rstmid.blocked", bus_fp.m0_gnt, 0);
    chk("rstmid.rvalid0", bus_fp.m0_rvalid, 1);
    chk("rstmid.rdata0", bus_fp.m0_rdata, pat(8'h33));
    tick();
    rst = 1'b0;
    drv(0, 0, 8'h00, 16'h0, 0, 0, 8'h00, 16'h0);
    sample();
    chk("rstmid.no_rvalid", bus_fp.m0_rvalid, 0);
    tick();

    // Random traffic with occasional reset
    for (int i = 0; i < 500; i++) begin
      rst = ($urandom_range(0, 39) == 0);
      drv($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, AW'($urandom_range(0, 15)), DW'($urandom),
          $urandom_range(0, 2) != 0, $urandom_range(0, 2) == 0, AW'($urandom_range(0, 15)), DW'($urandom));
      sample(); tick();
    end
    rst = 1'b0;
    drv(0, 0, 8'h00, 16'h0, 0, 0, 8'h00, 16'h0);
    sample(); tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Two-requester arbiter for the shared data RAM (read-port plus write-port RAM with 1-cycle registered read latency). Master 0 is the CPU load/store stage; master 1 is the external loader/debug port. The block grants at most one access per cycle. It routes read data back to the owning master with a valid strobe and prevents starvation of master 1 under fixed priority. It sits between the CPU datapath and the `ram` instance.

## Interface
- `AWIDTH`, 8, RAM address width
- `DWIDTH`, 16, RAM data width
- `FIXED_PRIO`, 1, 1 = master 0 has fixed priority with starvation guard; 0 = round-robin
- `STARVE_LIMIT`, 4, consecutive denied cycles of master 1 before a forced grant (1..15, used only when `FIXED_PRIO`=1)

Reset is synchronous, active-high (`rst`); clock is `clk`.

- `clk` in 1 system clock, all state on rising edge
- `rst` in 1 synchronous active-high reset
- `m0_req`, `m1_req` in 1 access request, level, held until granted
- `m0_we`, `m1_we` in 1 1 = write, 0 = read
- `m0_addr`, `m1_addr` in AWIDTH access address
- `m0_wdata`, `m1_wdata` in DWIDTH write data
- `m0_gnt`, `m1_gnt` out 1 combinational grant; the access occurs in the cycle where req&gnt
- `m0_rvalid`, `m1_rvalid` out 1 read data valid, registered
- `m0_rdata`, `m1_rdata` out DWIDTH read data; equals `ram_rdata` when the matching rvalid is high, else 0
- `ram_rd`, `ram_wr` out 1 RAM strobes, combinational from the granted master
- `ram_raddr`, `ram_waddr` out AWIDTH RAM addresses, 0 when idle
- `ram_wdata` out DWIDTH RAM write data, 0 when idle
- `ram_rdata` in DWIDTH RAM read data, valid one cycle after `ram_rd`

## Operation
- Grant decision is combinational from the req inputs and the registered state.
- Only one grant per cycle. While `rst`=1, both gnt outputs are 0 and the RAM strobes are 0.
- Single requester: granted in the same cycle, in any mode.
- Round-robin (`FIXED_PRIO`=0):
  - On conflict, grant the master that was not last granted.
  - `last_gnt` updates only on a grant; its reset value is 1, so master 0 wins the first conflict.
- Fixed priority (`FIXED_PRIO`=1):
  - On conflict, master 0 wins, unless the starve counter equals `STARVE_LIMIT`; then master 1 wins.
  - Starve counter (4 bits):
    - increments each cycle with `m1_req`=1 and `m1_gnt`=0;
    - clears on an `m1_gnt` or when `m1_req`=0;
    - saturates at `STARVE_LIMIT`;
    - reset value 0.
- Read tracking:
  - Registered `rd_owner` and `rd_pend` capture the granted master and `ram_rd` each cycle.
  - The next cycle, `mX_rvalid` = `rd_pend` & (`rd_owner`==X).
- Writes produce no response. A write is complete at the grant edge.
- Read-after-write to the same address in consecutive cycles follows RAM port behaviour; the arbiter adds no forwarding.
- Master inputs from a non-granted master are ignored entirely.

## Timing
Reset values:
- All gnt, rvalid, rdata and ram_* outputs: 0.
- `last_gnt`: 1.
- Starve counter: 0.
- `rd_pend`: 0.

Latency and throughput:
- Grant latency is 0 cycles from req when uncontended.
- Read data latency is exactly 1 cycle after the grant cycle.
- Throughput is 1 access per cycle; back-to-back reads from alternating masters pipeline with no bubble.

Boundary conditions:
- Reset mid-operation: if `rst` is asserted in a grant cycle, `rd_pend` clears at that edge and no rvalid is issued. A read granted the cycle before `rst` still returns rvalid in the cycle `rst` is high, because the flop was loaded before reset.
- Master dropping req without a grant: legal; no access, no state change except clearing the starve counter.
- Starve counter at `STARVE_LIMIT` with `m1_req` deasserted the same cycle: the counter clears and master 0 is granted normally.

## Test plan
- **Reset:** hold `rst` 3 cycles with both req=1. Required: gnt=0, ram_rd=ram_wr=0, rvalid=0 throughout; first post-reset conflict grants m0.
- **Solo read:** RAM[0x10]=0xBEEF; `m0_req`=1, we=0, addr=0x10 for 1 cycle. Required: `m0_gnt`=1 that cycle; next cycle `m0_rvalid`=1, `m0_rdata`=0xBEEF, `m1_rvalid`=0.
- **Round-robin:** `FIXED_PRIO`=0, both masters hold req=1 for 6 cycles. Required: grants m0,m1,m0,m1,m0,m1; each master's rvalid follows its grant by 1 cycle.
- **Starvation:** `FIXED_PRIO`=1, `STARVE_LIMIT`=4, both hold req. Required: m0 granted cycles 1–4, m1 granted cycle 5, m0 cycles 6–9, m1 cycle 10.
- **Write then read:** m1 writes 0x1234 to 0x05, then m0 reads 0x05 two cycles later. Required: `m0_rdata`=0x1234 with `m0_rvalid`; `ram_waddr`=0x05 only in the write cycle.
- **Reset mid-read:** m0 read granted at cycle t, `rst`=1 at cycle t+1. Required: `m0_rvalid`=1 at t+1 (pre-loaded); read granted at t+1 is blocked (gnt=0); no rvalid at t+2.
